// File: rtl/cbud_param.sv
// Cascadable up/down modulo counter with sync clear, preset and clamped load.
// Define CBUD_SAT_EN to saturate at the range ends instead of wrapping.
module cbud_param #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             CLK,
    input  logic             CS,
    input  logic             SD,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CAI,
    input  logic             DNUP,
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             TC,
    output logic             SAT
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] q_d, q_q;
    logic             tc_d, tc_q;
    logic             step;
    logic             at_bound;

    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                    input logic            down);
        logic [WIDTH-1:0] nxt;
        if (down)
            nxt = (cur == '0) ? MAX_V : cur - WIDTH'(1);
        else
            nxt = (cur == MAX_V) ? '0 : cur + WIDTH'(1);
        return nxt;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] din);
        return (din > MAX_V) ? MAX_V : din;
    endfunction

    always_comb begin
        step     = CAI && EN;
        at_bound = DNUP ? (q_q == '0) : (q_q == MAX_V);
    end

    // Carry-out ignores CS/SD/LD so a cascade sees the ripple in the same cycle.
    assign CAO = step && at_bound;

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (SD) begin
            q_d = MAX_V;
        end else if (LD) begin
            q_d = clamp_load(D);
        end else if (step) begin
            tc_d = at_bound;
`ifdef CBUD_SAT_EN
            q_d  = at_bound ? q_q : next_count(q_q, DNUP);
`else
            q_d  = next_count(q_q, DNUP);
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (CS) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q  = q_q;
    assign TC = tc_q;

`ifdef CBUD_SAT_EN
    logic sat_d, sat_q;

    // Sticky until an explicit clear, preset or load.
    always_comb begin
        sat_d = sat_q;
        if (SD || LD)
            sat_d = 1'b0;
        else if (step && at_bound)
            sat_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (CS)
            sat_q <= 1'b0;
        else
            sat_q <= sat_d;
    end

    assign SAT = sat_q;
`else
    assign SAT = 1'b0;
`endif

endmodule

// File: tb/tb_cbud_param.sv
// Scoreboard bench for cbud_param: a single mod-10 stage plus a two-stage mod-100 cascade.
module tb_cbud_param;

    localparam int W = 4;
    localparam int M = 10;

    logic         CLK = 1'b0;
    logic         cs = 1'b0, sd = 1'b0, ld = 1'b0, en = 1'b0, cai = 1'b0, dnup = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         cao, tc, sat;

    logic         cai_c = 1'b0;
    logic [W-1:0] lo_q, hi_q;
    logic         lo_cao, hi_cao, lo_tc, hi_tc, lo_sat, hi_sat;

    always #5 CLK = ~CLK;

    cbud_param #(.WIDTH(W), .MODULUS(M)) dut (
        .CLK(CLK), .CS(cs), .SD(sd), .LD(ld), .D(d), .EN(en), .CAI(cai), .DNUP(dnup),
        .Q(q), .CAO(cao), .TC(tc), .SAT(sat)
    );

    cbud_param #(.WIDTH(W), .MODULUS(M)) u_lo (
        .CLK(CLK), .CS(cs), .SD(1'b0), .LD(1'b0), .D('0), .EN(en), .CAI(cai_c), .DNUP(dnup),
        .Q(lo_q), .CAO(lo_cao), .TC(lo_tc), .SAT(lo_sat)
    );

    cbud_param #(.WIDTH(W), .MODULUS(M)) u_hi (
        .CLK(CLK), .CS(cs), .SD(1'b0), .LD(1'b0), .D('0), .EN(en), .CAI(lo_cao), .DNUP(dnup),
        .Q(hi_q), .CAO(hi_cao), .TC(hi_tc), .SAT(hi_sat)
    );

    typedef struct {
        int q;
        bit tc;
        bit sat;
        int cnt;
        bit ctc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference state: single stage value/flags, and the cascade as one integer 0..99.
    int m_q = 0;
    bit m_tc = 0, m_sat = 0;
    int m_cnt = 0;
    bit m_ctc = 0;

`ifdef CBUD_SAT_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input bit i_cs, input bit i_sd, input bit i_ld, input int i_d,
                       input bit i_en, input bit i_cai, input bit i_dn, input bit i_caic);
        exp_t e;
        bit   hit;
        @(negedge CLK);
        cs = i_cs; sd = i_sd; ld = i_ld; d = W'(i_d);
        en = i_en; cai = i_cai; dnup = i_dn; cai_c = i_caic;
        #1;
        if (!(i_cs && n_chk == 0)) begin
            hit = i_cai && i_en && (i_dn ? (m_q == 0) : (m_q == M - 1));
            chk("cao", cao, hit);
        end
        // single stage
        if (i_cs) begin
            m_q = 0; m_tc = 0; m_sat = 0;
        end else if (i_sd) begin
            m_q = M - 1; m_tc = 0; m_sat = 0;
        end else if (i_ld) begin
            m_q = (i_d < M) ? i_d : M - 1; m_tc = 0; m_sat = 0;
        end else if (i_en && i_cai) begin
            hit = i_dn ? (m_q == 0) : (m_q == M - 1);
            m_tc = hit;
            if (hit && SAT_MODE) m_sat = 1;
            else if (hit) m_q = i_dn ? M - 1 : 0;
            else m_q = i_dn ? m_q - 1 : m_q + 1;
        end else begin
            m_tc = 0;
        end
        // cascade as one mod-100 counter
        if (i_cs) begin
            m_cnt = 0; m_ctc = 0;
        end else if (i_en && i_caic) begin
            m_ctc = i_dn ? (m_cnt == 0) : (m_cnt == M * M - 1);
            m_cnt = i_dn ? (m_cnt + M * M - 1) % (M * M) : (m_cnt + 1) % (M * M);
        end else begin
            m_ctc = 0;
        end
        e.q = m_q; e.tc = m_tc; e.sat = m_sat; e.cnt = m_cnt; e.ctc = m_ctc;
        sb.push_back(e);
    endtask

    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("q", q, e.q);
            chk("tc", tc, e.tc);
            chk("sat", sat, e.sat);
            if (!SAT_MODE) begin
                chk("cascade", hi_q * M + lo_q, e.cnt);
                chk("cascade_tc", hi_tc, e.ctc);
            end
        end
    end

    initial begin
        // clear, then up 12 edges through 9->0
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (12) cyc(0, 0, 0, 0, 1, 1, 0, 1);
        // clamped load of 12, then down 10 edges through 0->9
        cyc(0, 0, 1, 12, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 1, 1, 1, 1);
        // simultaneous controls: clear wins, then preset alone
        cyc(1, 1, 1, 5, 1, 1, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        // saturate / wrap at top, then load back
        repeat (3) cyc(0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 3, 1, 1, 0, 0);
        // cascade from 0: 25 up edges, then hold with lo CAI low
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (25) cyc(0, 0, 0, 0, 1, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1, 1, 0, 0);
        // clear mid-count aborts the step
        cyc(1, 0, 0, 0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 0, 1);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
                $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)),
                $urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0,
                (i / 40) % 2 == 1 ? $urandom_range(0, 7) != 0 : $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) != 0);
        end
        repeat (3) @(posedge CLK);
        #2;
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cbud_param.md
CBUD_PARAM -- requirements
Module: cbud_param

Interface
REQ-001 Parameter WIDTH, default 8, counter bit width (2..32).
REQ-002 Parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH).
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 CS  input  1  reset, synchronous, active-high; clears counter.
REQ-005 SD  input  1  synchronous preset to MODULUS-1.
REQ-006 LD  input  1  synchronous parallel load from D.
REQ-007 D  input  WIDTH  load data.
REQ-008 EN  input  1  count enable.
REQ-009 CAI  input  1  carry-in from previous stage; count qualifier.
REQ-010 DNUP  input  1  direction; 0 = up, 1 = down.
REQ-011 Q  output  WIDTH  current count.
REQ-012 CAO  output  1  combinational carry-out to next stage.
REQ-013 TC  output  1  registered terminal-event pulse.
REQ-014 SAT  output  1  registered saturation flag (tied 0 when CBUD_SAT_EN undefined).

Function
REQ-015 Per-edge priority SHALL be CS > SD > LD > count > hold.
REQ-016 SD SHALL set Q = MODULUS-1.
REQ-017 LD SHALL set Q = D when D < MODULUS, else Q = MODULUS-1 (clamp).
REQ-018 Count step SHALL occur only when CAI && EN, by exactly 1.
REQ-019 Up count: Q = MODULUS-1 SHALL wrap to 0; otherwise Q+1.
REQ-020 Down count: Q = 0 SHALL wrap to MODULUS-1; otherwise Q-1.
REQ-021 CAO SHALL = CAI && EN && ((!DNUP && Q == MODULUS-1) || (DNUP && Q == 0)), zero latency, independent of CS/SD/LD.
REQ-022 TC SHALL assert for exactly one cycle, the cycle after an edge on which a count step crossed the boundary (wrap, or saturating hit per REQ-030); deasserted otherwise.
REQ-023 TC SHALL be 0 after any edge where CS, SD or LD won priority.
REQ-024 DNUP change with CAI && EN held SHALL take effect on the same edge; no pipeline stage.
REQ-025 Stages SHALL cascade: stage N+1 CAI = stage N CAO, common CLK/EN/DNUP, forming one MODULUS**k counter.
REQ-026 Q SHALL never hold a value >= MODULUS.

Reset
REQ-027 On CLK rising with CS = 1: Q = 0, TC = 0, SAT = 0, regardless of all other inputs.
REQ-028 CS mid-count SHALL abort the step; the following edge counts from 0.
REQ-029 No asynchronous state change SHALL exist; outputs before the first CS edge are undefined.

Configuration
REQ-030 Macro CBUD_SAT_EN: defined -> saturating mode: up step at MODULUS-1 and down step at 0 leave Q unchanged, set SAT = 1 (sticky) and pulse TC; CAO per REQ-021 unchanged.
REQ-031 CBUD_SAT_EN defined: SAT SHALL clear only on CS, SD or LD.
REQ-032 CBUD_SAT_EN undefined: wrap per REQ-019/020, SAT constant 0, no saturation logic synthesised.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-033 CS=1 one edge, then EN=CAI=1, DNUP=0, 12 edges -> Q 1..9,0,1,2; TC high one cycle after 9->0; CAO high while Q=9.
REQ-034 LD=1, D=4'hC -> Q=9; then DNUP=1, EN=CAI=1, 10 edges -> Q 8..0,9; TC pulse after 0->9.
REQ-035 Same edge CS=1, SD=1, LD=1, EN=CAI=1 -> Q=0, TC=0; next edge SD=1 only -> Q=9.
REQ-036 Two stages cascaded, all up from 0, 25 edges -> {hi,lo} = {2,5}; hi stage TC never pulses; CAI=0 on lo holds both.
REQ-037 CBUD_SAT_EN defined, Q=9, up count 3 edges -> Q stays 9, SAT=1, TC pulses each edge; LD D=3 -> Q=3, SAT=0.
REQ-038 WIDTH=8, MODULUS=256 default, up from 255 -> Q=0, TC pulse (undefined macro); CS pulse during count -> Q=0 next edge.
